// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for the arena display path.
// The defaults describe standard 640x480@60.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_HS_POL   = 1'b0;
    localparam bit VGA_VS_POL   = 1'b0;

    function automatic int span_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int width_for(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int VGA_H_TOTAL = span_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = span_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

endpackage

// File: rtl/vga_timing_clk_en_div.sv
// Board-clock to pixel-rate enable divider. The phase counter freezes while
// i_en is low, so a paused generator resumes mid-pixel exactly where it stopped.
module clk_en_div
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_stb
);

    localparam int DW = width_for(CLK_DIV);
    localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] d_reg;
    logic [DW-1:0] d_next;

    generate
        if (CLK_DIV < 1) begin : g_div_check
            $error("clk_en_div: CLK_DIV must be >= 1");
        end
    endgenerate

    always_comb begin
        d_next = d_reg;
        if (i_en) begin
            d_next = (d_reg == D_LAST) ? '0 : d_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            d_reg <= '0;
        end else begin
            d_reg <= d_next;
        end
    end

    assign o_stb = i_en && (d_reg == D_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA sync/beam generator: pixel enable, HS/VS, raw beam
// counters, line/frame strobes, frame counter and playfield wall flags.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = VGA_HS_POL,
    parameter bit VS_POL   = VGA_VS_POL,
    parameter int XW       = 10,
    parameter int YW       = 10,
    parameter int BORDER   = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic          o_pix_stb,
    output logic          o_hs,
    output logic          o_vs,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_active,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic [7:0]    o_frame_cnt,
    output logic          o_border_left,
    output logic          o_border_right,
    output logic          o_border_top
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [XW-1:0] H_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST = YW'(V_TOTAL - 1);

    generate
        if ((1 << XW) < H_TOTAL) begin : g_xw_check
            $error("vga_timing_gen: XW too narrow for H_TOTAL");
        end
        if ((1 << YW) < V_TOTAL) begin : g_yw_check
            $error("vga_timing_gen: YW too narrow for V_TOTAL");
        end
        if ((BORDER >= H_ACTIVE / 2) || (BORDER >= V_ACTIVE)) begin : g_border_check
            $error("vga_timing_gen: BORDER too large for the active area");
        end
    endgenerate

    logic          pix_stb;
    logic [XW-1:0] h_reg, h_next;
    logic [YW-1:0] v_reg, v_next;
    int            x_int, y_int;
    logic          active_next, line_start_next, frame_start_next;
    logic          hs_next, vs_next, left_next, right_next, top_next;

    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [7:0]    fcnt_reg;
    logic          hs_reg, vs_reg, active_reg, line_start_reg, frame_start_reg;
    logic          left_reg, right_reg, top_reg;

    clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .o_stb (pix_stb)
    );

    // Reset parks the beam on the last position so the first strobe lands on (0,0).
    always_comb begin
        h_next = h_reg + 1'b1;
        v_next = v_reg;
        if (h_reg == H_LAST) begin
            h_next = '0;
            v_next = (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
        end
    end

    always_comb begin
        x_int            = int'(h_next);
        y_int            = int'(v_next);
        active_next      = (x_int < H_ACTIVE) && (y_int < V_ACTIVE);
        line_start_next  = (x_int == 0);
        frame_start_next = (x_int == 0) && (y_int == 0);
        hs_next = ((x_int >= H_ACTIVE + H_FP) && (x_int < H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : !HS_POL;
        vs_next = ((y_int >= V_ACTIVE + V_FP) && (y_int < V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : !VS_POL;
        left_next  = active_next && (x_int < BORDER);
        right_next = active_next && (x_int >= H_ACTIVE - BORDER);
        top_next   = active_next && (y_int < BORDER);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_reg           <= H_LAST;
            v_reg           <= V_LAST;
            x_reg           <= '0;
            y_reg           <= '0;
            fcnt_reg        <= 8'hFF;
            hs_reg          <= !HS_POL;
            vs_reg          <= !VS_POL;
            active_reg      <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            left_reg        <= 1'b0;
            right_reg       <= 1'b0;
            top_reg         <= 1'b0;
        end else if (pix_stb) begin
            h_reg           <= h_next;
            v_reg           <= v_next;
            x_reg           <= h_next;
            y_reg           <= v_next;
            hs_reg          <= hs_next;
            vs_reg          <= vs_next;
            active_reg      <= active_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
            left_reg        <= left_next;
            right_reg       <= right_next;
            top_reg         <= top_next;
            if (frame_start_next) begin
                fcnt_reg <= fcnt_reg + 8'd1;
            end
        end
    end

    assign o_pix_stb      = pix_stb;
    assign o_hs           = hs_reg;
    assign o_vs           = vs_reg;
    assign o_x            = x_reg;
    assign o_y            = y_reg;
    assign o_active       = active_reg;
    assign o_line_start   = line_start_reg;
    assign o_frame_start  = frame_start_reg;
    assign o_frame_cnt    = fcnt_reg;
    assign o_border_left  = left_reg;
    assign o_border_right = right_reg;
    assign o_border_top   = top_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny instance,
// both compared every clock against a beam-position model derived from enable counts.
module tb_vga_timing_gen;

    typedef struct {
        int div, ha, hf, hsw, hb, va, vf, vsw, vb, border;
        bit hpol, vpol;
    } cfg_t;

    typedef struct {
        int x, y, fc;
        bit stb, hs, vs, act, ls, fs, bl, br, bt;
    } exp_t;

    cfg_t cfg_a = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 8, 1'b0, 1'b0};
    cfg_t cfg_b = '{3, 8, 1, 2, 1, 4, 1, 1, 1, 2, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, en_a = 1'b0, rst_b = 1'b1, en_b = 1'b0;
    logic a_stb, a_hs, a_vs, a_act, a_ls, a_fs, a_bl, a_br, a_bt;
    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;
    logic b_stb, b_hs, b_vs, b_act, b_ls, b_fs, b_bl, b_br, b_bt;
    logic [3:0] b_x;
    logic [2:0] b_y;
    logic [7:0] b_fc;

    int passed = 0;
    int total  = 0;

    vga_timing_gen dut_a (
        .i_clk(clk), .i_rst(rst_a), .i_en(en_a), .o_pix_stb(a_stb), .o_hs(a_hs), .o_vs(a_vs),
        .o_x(a_x), .o_y(a_y), .o_active(a_act), .o_line_start(a_ls), .o_frame_start(a_fs),
        .o_frame_cnt(a_fc), .o_border_left(a_bl), .o_border_right(a_br), .o_border_top(a_bt)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .XW(4), .YW(3), .BORDER(2)
    ) dut_b (
        .i_clk(clk), .i_rst(rst_b), .i_en(en_b), .o_pix_stb(b_stb), .o_hs(b_hs), .o_vs(b_vs),
        .o_x(b_x), .o_y(b_y), .o_active(b_act), .o_line_start(b_ls), .o_frame_start(b_fs),
        .o_frame_cnt(b_fc), .o_border_left(b_bl), .o_border_right(b_br), .o_border_top(b_bt)
    );

    // Beam state follows from how many enabled clocks have elapsed since reset.
    function automatic exp_t model(cfg_t c, longint n, bit en);
        exp_t e;
        int ht, vt;
        longint k, p;
        ht = c.ha + c.hf + c.hsw + c.hb;
        vt = c.va + c.vf + c.vsw + c.vb;
        e = '{default: 0};
        e.stb = en && ((n % c.div) == c.div - 1);
        k = n / c.div;
        if (k == 0) begin
            e.fc = 255;
            e.hs = !c.hpol;
            e.vs = !c.vpol;
            return e;
        end
        p    = (k - 1) % (ht * vt);
        e.x  = int'(p % ht);
        e.y  = int'(p / ht);
        e.fc = int'(((k - 1) / (ht * vt)) % 256);
        e.act = (e.x < c.ha) && (e.y < c.va);
        e.ls  = (e.x == 0);
        e.fs  = (e.x == 0) && (e.y == 0);
        e.hs  = ((e.x >= c.ha + c.hf) && (e.x < c.ha + c.hf + c.hsw)) ? c.hpol : !c.hpol;
        e.vs  = ((e.y >= c.va + c.vf) && (e.y < c.va + c.vf + c.vsw)) ? c.vpol : !c.vpol;
        e.bl  = e.act && (e.x < c.border);
        e.br  = e.act && (e.x >= c.ha - c.border);
        e.bt  = e.act && (e.y < c.border);
        return e;
    endfunction

    function automatic logic [48:0] pack_exp(exp_t e);
        return {16'(e.x), 16'(e.y), 8'(e.fc), e.stb, e.hs, e.vs, e.act, e.ls, e.fs, e.bl, e.br, e.bt};
    endfunction

    task automatic check1(string name, longint act, longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_vec(string name, logic [48:0] act, logic [48:0] exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s @%0t: got x=%0d y=%0d fc=%0d flags=%b, expected x=%0d y=%0d fc=%0d flags=%b",
                      name, $time, act[48:33], act[32:17], act[16:9], act[8:0],
                      exp[48:33], exp[32:17], exp[16:9], exp[8:0]);
    endtask

    longint n_a = 0, n_b = 0;
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) n_a <= 0;
        else if (en_a) n_a <= n_a + 1;
    end
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) n_b <= 0;
        else if (en_b) n_b <= n_b + 1;
    end

    logic [48:0] act_a, act_b;
    assign act_a = {16'(a_x), 16'(a_y), a_fc, a_stb, a_hs, a_vs, a_act, a_ls, a_fs, a_bl, a_br, a_bt};
    assign act_b = {16'(b_x), 16'(b_y), b_fc, b_stb, b_hs, b_vs, b_act, b_ls, b_fs, b_bl, b_br, b_bt};

    always @(negedge clk) begin
        check_vec("a_cycle", act_a, pack_exp(model(cfg_a, n_a, en_a)));
        check_vec("b_cycle", act_b, pack_exp(model(cfg_b, n_b, en_b)));
    end

    task automatic next_stb_a(output int waited);
        bit ok = 0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            if (a_stb) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        if (!ok) check1("a_stb_timeout", 0, 1);
    endtask

    task automatic next_stb_b(output int waited);
        bit ok = 0;
        waited = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waited++;
            if (b_stb) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        if (!ok) check1("b_stb_timeout", 0, 1);
    endtask

    task automatic flow_a();
        int w, since_ls, hs_low;
        repeat (3) @(posedge clk);
        #1;
        check1("a_rst_x", a_x, 0);
        check1("a_rst_fc", a_fc, 255);
        check1("a_rst_hs", a_hs, 1);
        check1("a_rst_act", a_act, 0);
        rst_a = 1'b0;
        @(posedge clk); #1;
        en_a = 1'b1;
        next_stb_a(w);
        check1("a_first_stb_delay", w, 2);
        check1("a_first_x", a_x, 0);
        check1("a_first_y", a_y, 0);
        check1("a_first_flags", {a_act, a_ls, a_fs}, 3'b111);
        check1("a_first_fc", a_fc, 0);
        since_ls = 0;
        hs_low   = 0;
        for (int s = 0; s < 2000; s++) begin
            next_stb_a(w);
            if (s == 0) check1("a_stb_spacing", w, 2);
            since_ls++;
            if (a_ls) begin
                check1("a_line_len", since_ls, 800);
                check1("a_hs_width", hs_low, 96);
                since_ls = 0;
                hs_low   = 0;
            end
            if (!a_hs) hs_low++;
            case (a_x)
                10'd5:   if (a_y == 0) check1("a_top_y0", a_bt, 1);
                10'd7:   check1("a_left_7", a_bl, 1);
                10'd8:   check1("a_left_8", a_bl, 0);
                10'd631: check1("a_right_631", a_br, 0);
                10'd632: check1("a_right_632", a_br, 1);
                10'd640: check1("a_x640", {a_act, a_br}, 2'b00);
                10'd655: check1("a_hs_655", a_hs, 1);
                10'd656: check1("a_hs_656", a_hs, 0);
                10'd700: check1("a_walls_700", {a_bl, a_br, a_bt}, 3'b000);
                10'd751: check1("a_hs_751", a_hs, 0);
                10'd752: check1("a_hs_752", a_hs, 1);
                default: ;
            endcase
            if (a_y == 2 && a_x == 100) break;
        end
        en_a = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check1("a_frz_stb", a_stb, 0);
            check1("a_frz_x", a_x, 100);
        end
        @(posedge clk); #1;
        en_a = 1'b1;
        next_stb_a(w);
        check1("a_resume_x", a_x, 101);
    endtask

    task automatic flow_b();
        int w, frames, since_fs;
        repeat (3) @(posedge clk);
        #1;
        rst_b = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            en_b = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_b = 1'b1;
                @(posedge clk); #1;
                rst_b = 1'b0;
            end
        end
        @(posedge clk); #2;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        en_b  = 1'b1;
        frames   = 0;
        since_fs = 0;
        for (int s = 0; s < 257 * 84 + 100; s++) begin
            next_stb_b(w);
            since_fs++;
            if (b_fs) begin
                frames++;
                if (frames > 1) check1("b_frame_len", since_fs, 84);
                since_fs = 0;
                if (frames == 1) check1("b_fc_frame1", b_fc, 0);
                if (frames == 2) check1("b_fc_frame2", b_fc, 1);
                if (frames == 257) begin
                    check1("b_fc_wrap", b_fc, 0);
                    break;
                end
            end
            if (frames == 1) begin
                if (b_x == 8)  check1("b_hs_8", b_hs, 0);
                if (b_x == 9)  check1("b_hs_9", b_hs, 1);
                if (b_x == 10) check1("b_hs_10", b_hs, 1);
                if (b_x == 11) check1("b_hs_11", b_hs, 0);
                if (b_x == 0 && b_y == 4) check1("b_vs_4", b_vs, 1);
                if (b_x == 0 && b_y == 5) check1("b_vs_5", b_vs, 0);
                if (b_x == 0 && b_y == 6) check1("b_vs_6", b_vs, 1);
                if (b_x == 1 && b_y == 0) check1("b_corner", {b_bl, b_bt}, 2'b11);
                if (b_x == 6 && b_y == 2) check1("b_right_6", b_br, 1);
                if (b_x == 5 && b_y == 2) check1("b_right_5", b_br, 0);
                if (b_x == 3 && b_y == 2) check1("b_top_y2", b_bt, 0);
            end
        end
        check1("b_frames_seen", frames, 257);
        repeat (30) next_stb_b(w);
        #1 rst_b = 1'b1;
        #1;
        check1("b_arst_x", b_x, 0);
        check1("b_arst_y", b_y, 0);
        check1("b_arst_fc", b_fc, 255);
        check1("b_arst_sync", {b_hs, b_vs}, 2'b01);
        check1("b_arst_flags", {b_act, b_ls, b_fs}, 3'b000);
        @(posedge clk); #1;
        rst_b = 1'b0;
        next_stb_b(w);
        check1("b_post_rst_delay", w, 3);
        check1("b_post_rst_xy", {b_x, b_y}, 7'd0);
        check1("b_post_rst_fc", b_fc, 0);
        check1("b_post_rst_fs", {b_ls, b_fs}, 2'b11);
    endtask

    initial begin
        fork
            flow_a();
            flow_b();
        join
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete, passed=%0d total=%0d", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 timing path used by the arena display.
- Derives its own pixel-clock enable from the board clock, with a configurable divide ratio.
- Generates HS/VS with programmable timing and polarity, plus raw beam counters.
- Adds line/frame strobes, a frame counter and playfield-wall region flags that the current path lacks. Game-logic and renderer blocks consume all outputs directly.

Parameters:
- CLK_DIV, 2: board clocks per pixel; must be >=1. CLK_DIV=1 gives a strobe every clock.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch (pixels).
- H_SYNC, 96: horizontal sync width (pixels).
- H_BP, 48: horizontal back porch (pixels).
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch (lines).
- V_SYNC, 2: vertical sync width (lines).
- V_BP, 33: vertical back porch (lines).
- HS_POL, 0: asserted level of o_hs.
- VS_POL, 0: asserted level of o_vs.
- XW, 10: width of o_x; elaboration error if 2^XW < H_TOTAL.
- YW, 10: width of o_y; elaboration error if 2^YW < V_TOTAL.
- BORDER, 8: wall thickness in pixels; must be < H_ACTIVE/2 and < V_ACTIVE.

Ports:
- i_clk  in  1  board clock.
- i_rst  in  1  reset.
- i_en  in  1  run enable; low freezes the generator.
- o_pix_stb  out  1  one-clock pulse per pixel period.
- o_hs  out  1  horizontal sync.
- o_vs  out  1  vertical sync.
- o_x  out  XW  raw horizontal counter, 0..H_TOTAL-1.
- o_y  out  YW  raw vertical counter, 0..V_TOTAL-1.
- o_active  out  1  beam is in the visible area.
- o_line_start  out  1  first pixel of a line.
- o_frame_start  out  1  first pixel of a frame.
- o_frame_cnt  out  8  frame counter.
- o_border_left  out  1  beam is in the left wall.
- o_border_right  out  1  beam is in the right wall.
- o_border_top  out  1  beam is in the top wall.

Interface (already decided): one clock, i_clk; reset i_rst is asynchronous and active-high.

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Region order within a line and within a frame: active, front porch, sync, back porch.
- Divider:
  - Counter d runs 0..CLK_DIV-1, advancing while i_en=1.
  - o_pix_stb=1 in the clock where d==CLK_DIV-1 and i_en=1; otherwise 0.
- Counters:
  - On each strobe, h advances; at H_TOTAL-1 it wraps to 0 and v advances.
  - v wraps from V_TOTAL-1 to 0.
- Reset values (asynchronous, applied immediately, including mid-frame):
  - d=0; h=H_TOTAL-1; v=V_TOTAL-1.
  - o_x=0, o_y=0, o_frame_cnt=8'hFF.
  - o_hs=~HS_POL, o_vs=~VS_POL.
  - All other outputs 0.
- Output timing:
  - All outputs except o_pix_stb are registered.
  - They update only on the edge that ends a strobe clock, from the next-state counters, so they describe the new beam position and hold for one full pixel period.
  - The first strobe after reset therefore presents (0,0) with o_active=1, o_line_start=1, o_frame_start=1 and o_frame_cnt=0.
- Decoding:
  - o_active = (x<H_ACTIVE) && (y<V_ACTIVE).
  - o_line_start = (x==0).
  - o_frame_start = (x==0 && y==0).
  - o_hs asserted (=HS_POL) iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - o_vs asserted (=VS_POL) iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; it is line-granular and changes at x==0.
- Frame counter: increments by 1 when o_frame_start is registered high; wraps from 255 to 0.
- Border flags, all gated by o_active:
  - o_border_left when x<BORDER.
  - o_border_right when x>=H_ACTIVE-BORDER.
  - o_border_top when y<BORDER.
  - Left and top may both assert at the corner.
- i_en=0:
  - d holds, no strobe, all counters and outputs hold.
  - On re-enable, the divider resumes from its held value.
- i_rst asserted during i_en=1 or mid-strobe: reset wins.

Decomposition:
- Shared package vga_timing_pkg holds:
  - 640x480@60 constants (H/V active, porches, sync, totals, polarities).
  - An H_TOTAL/V_TOTAL computation function.
  - A clog2-style width helper.
- One sub-module: clk_en_div, the CLK_DIV divider with enable hold that produces o_pix_stb.
- The counter, decode and register logic stay in vga_timing_gen.

Test Plan:
1. Reset, then i_en=1 with CLK_DIV=2 → o_pix_stb on every 2nd clock. First strobe gives x=0, y=0, active=1, line_start=1, frame_start=1, frame_cnt=0.
2. Default timing, line check → exactly 800 strobes between line_start pulses. o_hs=0 for x=656..751 (96 pixels), 1 elsewhere.
3. Full frames → 420000 strobes between frame_start pulses. o_vs=0 for y=490..491. frame_cnt=1 on the second frame, and 0 after 256 frames.
4. Border check, BORDER=8 → left high at x=0..7; right high at x=632..639; top high at y=0..7; all low at x=700 and at y=500.
5. i_en low for 10 clocks while x=100 → no strobes and all outputs frozen; the next strobe after re-enable gives x=101.
6. Small config (H 8/1/2/1, V 4/1/1/1, CLK_DIV=3, HS_POL=1): two frames compared cycle-by-cycle against a reference model. Then i_rst pulsed between clock edges mid-frame → outputs take reset values before the next edge, and the first strobe after release gives (0,0) with frame_cnt=0.
